// File: rtl/fifo_split.sv
// Width-down FIFO: stores wide words and hands them out as narrow sub-words,
// least-significant sub-word first, with first-word fall-through on the read side.
module fifo_split #(
    parameter int IN_DATA_WIDTH  = 128,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int DEPTH          = 4,
    localparam int RATIO         = IN_DATA_WIDTH / OUT_DATA_WIDTH,
    localparam int LVL_W         = $clog2(DEPTH * RATIO) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IN_DATA_WIDTH-1:0]  data_i,
    input  logic                      write_valid_i,
    output logic                      write_ready_o,
    output logic                      read_valid_o,
    input  logic                      read_ready_i,
    output logic [OUT_DATA_WIDTH-1:0] data_o,
    output logic [LVL_W-1:0]          level_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SEL_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IN_DATA_WIDTH-1:0] mem [DEPTH];
    logic [IN_DATA_WIDTH-1:0] rd_word;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [SEL_W-1:0] sel;
    logic             last_sub;
    logic             write_hs;
    logic             read_hs;
    logic             free_hs;

    // Pointers wrap explicitly so non-power-of-2 depths work; full/empty come from count.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign write_ready_o = (count_reg < CNT_W'(DEPTH));
    assign read_valid_o  = (count_reg != '0);
    assign write_hs      = write_valid_i & write_ready_o;
    assign read_hs       = read_valid_o & read_ready_i;
    assign free_hs       = read_hs & last_sub;
    assign rd_word       = mem[rd_ptr_reg];
    assign level_o       = LVL_W'(count_reg) * LVL_W'(RATIO) - LVL_W'(sel);

    always_ff @(posedge clk) begin
        if (rst_n && write_hs) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (write_hs && !free_hs) begin
            count_next = count_reg + 1'b1;
        end else if (free_hs && !write_hs) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (write_hs) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (free_hs) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_next;
        end
    end

    generate
        if (RATIO > 1) begin : g_split
            logic [SEL_W-1:0]          sel_reg;
            logic [OUT_DATA_WIDTH-1:0] sub_words [RATIO];

            for (genvar gi = 0; gi < RATIO; gi++) begin : g_sub
                assign sub_words[gi] = rd_word[gi*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
            end

            // An entry is held until its last sub-word has been taken.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sel_reg <= '0;
                end else if (read_hs) begin
                    sel_reg <= last_sub ? '0 : sel_reg + 1'b1;
                end
            end

            assign sel      = sel_reg;
            assign last_sub = (sel_reg == SEL_W'(RATIO - 1));
            assign data_o   = sub_words[sel_reg];
        end else begin : g_plain
            assign sel      = '0;
            assign last_sub = 1'b1;
            assign data_o   = rd_word;
        end
    endgenerate

endmodule
